// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Control FSM for the iterative signed Booth multiplier / restoring divider
//   datapath. It accepts one MUL/DIV request, latches the operands and
//   sequences the datapath through one load strobe and a fixed number of step
//   strobes. It then captures the 64-bit result into HI/LO. A divide by zero
//   completes in one cycle and never touches the datapath.
//
//   Optional build macro: MULDIV_RADIX4_EN
//     When defined, MUL runs STEPS/2 step cycles in radix-4 Booth mode, and the
//     extra output dp_radix4 tells the datapath which mode to use.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start, op            request strobe (sampled in IDLE), 0 = MUL, 1 = DIV
//   operand_a/_b         multiplicand/dividend, multiplier/divisor
//   busy                 operation in flight (pipeline stall)
//   done                 one-cycle pulse when HI/LO are updated
//   div_by_zero          set by a divide by zero, held until the next accepted start
//   hi_out, lo_out       MUL: product high/low, DIV: remainder/quotient
//   dp_load, dp_step     datapath initialise / one-iteration strobes
//   dp_op, dp_a, dp_b    latched request, stable while busy
//   dp_radix4            (MULDIV_RADIX4_EN only) radix-4 Booth mode select
//   dp_hi, dp_lo         datapath results, sampled in CAPTURE only
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
`ifdef MULDIV_RADIX4_EN
  output logic             dp_radix4,
`endif
  input  logic [WIDTH-1:0] dp_hi,
  input  logic [WIDTH-1:0] dp_lo
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_STEP    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(STEPS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] last_cnt_s;
  logic             div_zero_req_s;

  // Counter value of the final step cycle for the latched operation.
  always_comb begin
    last_cnt_s = LAST_FULL;
`ifdef MULDIV_RADIX4_EN
    if (op_q == 1'b0) begin
      last_cnt_s = LAST_HALF;
    end else begin
      last_cnt_s = LAST_FULL;
    end
`endif
  end

  assign div_zero_req_s = op && (operand_b == {WIDTH{1'b0}});

  // Next-state and next-register logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (div_zero_req_s) begin
            // Divide by zero completes here without running the datapath.
            hi_d   = operand_a;
            lo_d   = {WIDTH{1'b1}};
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            op_d    = op;
            a_d     = operand_a;
            b_d     = operand_b;
            dbz_d   = 1'b0;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_ZERO;
        state_d = S_STEP;
      end
      S_STEP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == last_cnt_s) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_CAPTURE: begin
        hi_d    = dp_hi;
        lo_d    = dp_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath-facing registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      op_q    <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Strobes decode registered state only, so they fall with an asynchronous reset.
  assign busy        = (state_q != S_IDLE);
  assign dp_load     = (state_q == S_LOAD);
  assign dp_step     = (state_q == S_STEP);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign dp_op       = op_q;
  assign dp_a        = a_q;
  assign dp_b        = b_q;
`ifdef MULDIV_RADIX4_EN
  assign dp_radix4   = busy && (op_q == 1'b0);
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_RADIX4_EN
  localparam int MUL_STEPS = 16;
`else
  localparam int MUL_STEPS = 32;
`endif
  localparam int DIV_STEPS = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;
  logic         dp_load, dp_step, dp_op;
  logic [W-1:0] dp_a, dp_b;
  logic [W-1:0] dp_hi, dp_lo;
`ifdef MULDIV_RADIX4_EN
  logic         dp_radix4;
`endif

  muldiv_sequencer #(.WIDTH(32), .STEPS(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out),
    .dp_load(dp_load), .dp_step(dp_step), .dp_op(dp_op),
    .dp_a(dp_a), .dp_b(dp_b),
`ifdef MULDIV_RADIX4_EN
    .dp_radix4(dp_radix4),
`endif
    .dp_hi(dp_hi), .dp_lo(dp_lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic of a signed multiplier / truncating divider.
  function automatic logic [63:0] ref_result(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Behavioural datapath: the true result appears only after the right step count.
  logic [63:0] dp_res;
  int          dp_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_res <= 64'd0;
      dp_cnt <= 0;
    end else if (dp_load) begin
      dp_res <= ref_result(dp_op, dp_a, dp_b);
      dp_cnt <= 0;
    end else if (dp_step) begin
      dp_cnt <= dp_cnt + 1;
    end
  end
  assign dp_hi = (dp_cnt == (dp_op ? DIV_STEPS : MUL_STEPS)) ? dp_res[63:32] : ~dp_res[63:32];
  assign dp_lo = (dp_cnt == (dp_op ? DIV_STEPS : MUL_STEPS)) ? dp_res[31:0]  : ~dp_res[31:0];

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           busyc;
    int           steps;
    int           loads;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  // Monitor: counts strobes and compares each done pulse with the scoreboard.
  int mon_steps = 0, mon_loads = 0, mon_busy = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mon_steps = 0; mon_loads = 0; mon_busy = 0;
    end else begin
      if (busy) mon_busy++;
      if (dp_step) mon_steps++;
      if (dp_load) begin
        mon_loads++;
        if (exp_q.size() == 0) begin
          check("load_without_request", 64'd1, 64'd0);
        end else begin
          check("dp_op", 64'(dp_op), 64'(exp_q[0].op));
          check("dp_a", 64'(dp_a), 64'(exp_q[0].a));
          check("dp_b", 64'(dp_b), 64'(exp_q[0].b));
        end
      end
`ifdef MULDIV_RADIX4_EN
      check("dp_radix4", 64'(dp_radix4), 64'(busy && !dp_op));
`endif
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi_out", 64'(hi_out), 64'(e.hi));
          check("lo_out", 64'(lo_out), 64'(e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          check("busy_cycles", 64'(mon_busy), 64'(e.busyc));
          check("step_count", 64'(mon_steps), 64'(e.steps));
          check("load_count", 64'(mon_loads), 64'(e.loads));
        end
        mon_steps = 0; mon_loads = 0; mon_busy = 0;
      end
    end
  end

  // Issue one accepted request (caller is at a negedge) and queue its expectation.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] r;
    r = ref_result(o, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.op = o; e.a = a; e.b = b;
    e.start_cyc = cyc;
    if (o && b == 32'd0) begin
      e.dbz = 1'b1; e.lat = 1; e.busyc = 0; e.steps = 0; e.loads = 0;
    end else begin
      e.dbz = 1'b0;
      e.steps = o ? DIV_STEPS : MUL_STEPS;
      e.lat = e.steps + 3; e.busyc = e.steps + 2; e.loads = 1;
    end
    exp_q.push_back(e);
    last_exp = e;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = $urandom_range(0, 1); operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(o, a, b);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_hi", 64'(hi_out), 64'(last_exp.hi));
    check("hold_lo", 64'(lo_out), 64'(last_exp.lo));
    check("hold_dbz", 64'(div_by_zero), 64'(last_exp.dbz));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    logic o;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_strobes", {62'd0, dp_load, dp_step}, 64'd0);
    check("rst_dp_regs", {dp_a, dp_b}, 64'd0);
    check("rst_dp_op", 64'(dp_op), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    run(1'b0, 32'd7, 32'hFFFF_FFFD);
    run(1'b1, 32'd100, 32'd7);
    run(1'b1, 32'h1234_5678, 32'd0);
    run(1'b0, 32'd3, 32'd5);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1'b1, 32'hFFFF_FF9C, 32'd7);

    // Starts in cycles 5 and 20 of a running MUL are ignored.
    issue(1'b0, 32'd1234, 32'hFFFF_0001);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; operand_a = 32'hDEAD_BEEF; operand_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; op = 1'b0; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    // Start in the done cycle is accepted.
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    issue(1'b1, 32'd1000, 32'd33);
    check("busy_after_done_start", 64'(busy), 64'd1);
    check("done_fell", 64'(done), 64'd0);
    wait_done();

    // Reset in cycle 10 of a DIV.
    @(negedge clk);
    issue(1'b1, 32'd5000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_step", 64'(dp_step), 64'd0);
    check("midrst_hi", 64'(hi_out), 64'd0);
    check("midrst_lo", 64'(lo_out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(1'b0, 32'hFFFF_FFF0, 32'd16);

    // Randomised operations.
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(0, 20)) - 32'd10;
        default: b = 32'($urandom);
      endcase
      run(o, a, b);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Control FSM for the team's iterative signed Booth multiplier and restoring divider datapath.
- Accepts one MUL/DIV request from the CPU execute stage and latches the operands.
- Drives the datapath load/step strobes for a fixed iteration count, then captures the 64-bit result into HI/LO registers.
- Generates the busy stall for the pipeline and short-circuits divide-by-zero without touching the datapath.

Parameters:
- WIDTH, 32: operand width; HI/LO are WIDTH each.
- STEPS, 32: datapath iterations per operation. Must equal WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > STEPS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  1  0 = signed MUL, 1 = signed DIV.
- operand_a  in  WIDTH  multiplicand / dividend.
- operand_b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight; the CPU stalls on it.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_by_zero  out  1  sticky per operation; valid while done is high and held until the next accepted start.
- hi_out  out  WIDTH  MUL: product[63:32]; DIV: remainder.
- lo_out  out  WIDTH  MUL: product[31:0]; DIV: quotient.
- dp_load  out  1  datapath initialise strobe.
- dp_step  out  1  datapath one-iteration strobe (add/sub + shift).
- dp_op  out  1  latched op, stable while busy.
- dp_a  out  WIDTH  latched operand_a, stable while busy.
- dp_b  out  WIDTH  latched operand_b, stable while busy.
- dp_hi  in  WIDTH  datapath upper result.
- dp_lo  in  WIDTH  datapath lower result.

Behaviour:
- Reset values (asynchronous): state = IDLE; counter, busy, done, div_by_zero, dp_load, dp_step = 0; hi_out, lo_out, dp_a, dp_b = 0; dp_op = 0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- States: IDLE, LOAD, STEP, CAPTURE.
- IDLE:
  - start=1 and not (op=1 and operand_b=0): latch op/a/b, clear div_by_zero, go to LOAD.
  - start=1 and op=1 and operand_b=0: stay in IDLE. At that edge set hi_out=operand_a, lo_out={WIDTH{1}}, div_by_zero=1, done=1 for the next cycle. dp_load is never asserted. Latency is 1 cycle.
- LOAD: dp_load=1 for exactly one cycle; counter=0. Next state is STEP.
- STEP:
  - dp_step=1 every cycle; counter increments each edge.
  - When counter=STEPS-1 at the edge, go to CAPTURE. This gives exactly STEPS step cycles.
- CAPTURE:
  - At the edge, hi_out<=dp_hi, lo_out<=dp_lo, done<=1, state<=IDLE.
  - dp_hi/dp_lo are sampled only in this state.
- busy = (state != IDLE).
- Normal latency: start cycle = 0, LOAD = cycle 1, STEP = cycles 2..STEPS+1, CAPTURE = cycle STEPS+2, done high in cycle STEPS+3. That is 35 cycles for the default parameters.
- start while busy=1 is ignored and does not queue.
- start in the same cycle that done is high is accepted (state is IDLE). done then falls next cycle and busy rises.
- done is high for exactly one cycle per operation. hi_out/lo_out hold between operations.
- Reset mid-operation: immediate return to IDLE. Strobes drop asynchronously, HI/LO clear, and no done pulse is produced.
- Result signedness and rounding (truncating quotient, remainder takes dividend's sign) are produced by the datapath. The sequencer only routes results.

Optional Feature:
- MULDIV_RADIX4_EN defined: MUL uses STEPS/2 step cycles, with the datapath in radix-4 Booth mode. The extra output dp_radix4 (1 bit) equals the latched op==0 while busy. MUL latency becomes 19 cycles; DIV is unchanged at 35.
- Not defined: dp_radix4 is absent and all ops use STEPS step cycles.

Test Plan:
- MUL a=7, b=-3 -> busy cycles 1..34; exactly one dp_load and 32 dp_step; done in cycle 35; model datapath returns -21, so hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=100, b=7 -> done in cycle 35; hi=2, lo=14; div_by_zero=0.
- DIV a=0x12345678, b=0 -> done in cycle 1; hi=0x12345678, lo=0xFFFFFFFF; div_by_zero=1; dp_load never high.
- start pulsed in cycles 5 and 20 of a running MUL -> both ignored, single done; a start in the done cycle begins a new op with busy high the next cycle.
- reset asserted in cycle 10 of a DIV -> busy/dp_step low immediately; hi/lo = 0; no done; a new MUL afterwards completes normally.
- With MULDIV_RADIX4_EN: MUL 3 x 5 -> 16 dp_step pulses, done in cycle 19, lo=15; DIV still takes 32 steps.
